multicycle_ctrl: RTL
====================

# multicycle_ctrl

Moore-style control FSM for the RV32I multicycle core: sits directly upstream of `datapath` and drives every one of its control inputs (`pc_write`, `ir_write`, `mem_write`, `reg_write`, `mdr_write`, `imm_ctrl`, `alu_ctrl`, `alu_in2_ctrl`, `addrsrc_ctrl`, `regwrite_ctrl`). It decodes the opcode and funct fields of the registered instruction (IR output) and sequences fetch, decode, execute, memory and write-back cycles. Supported subset: R-type ALU, I-type ALU, LW and SW. It also keeps a retired-instruction counter.

## Interface
- `CNT_W`, default 32, width of the retired-instruction counter.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `opcode` input 7: IR[6:0].
- `funct3` input 3: IR[14:12].
- `funct7b5` input 1: IR[30].
- `pc_write`, `ir_write`, `mem_write`, `reg_write`, `mdr_write` output 1 each: datapath write enables.
- `imm_ctrl` output 3: immediate format. I=000, S=001, B=010, U=011, J=100.
- `alu_ctrl` output 4: ALU operation. ADD=0000, SUB=0001, SLL=0010, SLT=0011, SLTU=0100, XOR=0101, SRL=0110, SRA=0111, OR=1000, AND=1001.
- `alu_in2_ctrl` output 1: ALU operand 2 select. 0 = rs2 register, 1 = immediate.
- `addrsrc_ctrl` output 1: memory address select. 0 = PC, 1 = ALU result register.
- `regwrite_ctrl` output 1: register-file write data select. 0 = ALU result register, 1 = MDR.
- `state_o` output 4: current state encoding (debug).
- `retired` output 1: one-cycle pulse in the last cycle of each legal instruction.
- `retire_count` output CNT_W: number of retired instructions.
- `illegal` output 1: sticky illegal-instruction flag (only with the macro in Configuration).

## Operation
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, TRAP=9.
- All outputs are a function of the state only; there is no Mealy path from the inputs to the outputs.
- Default value of every output is 0 in every state, except where a state below sets it.
- FETCH:
  - asserts `pc_write`=1, `ir_write`=1, `addrsrc_ctrl`=0.
  - always goes to DECODE.
- DECODE:
  - all write enables 0; the datapath latches rs1/rs2 during this cycle.
  - Next state by `opcode`:
    - 0000011 with `funct3`=010 → MEMADR.
    - 0100011 with `funct3`=010 → MEMADR.
    - 0110011 → EXECR.
    - 0010011 → EXECI.
    - anything else → illegal handling (see Configuration).
- MEMADR:
  - `alu_in2_ctrl`=1, `alu_ctrl`=ADD.
  - `imm_ctrl`=001 if `opcode` is store, else 000.
  - Next state: MEMWRITE for a store, MEMREAD for a load.
- MEMWRITE: `addrsrc_ctrl`=1, `mem_write`=1, `retired`=1; → FETCH.
- MEMREAD: `addrsrc_ctrl`=1, `mdr_write`=1; → MEMWB.
- MEMWB: `reg_write`=1, `regwrite_ctrl`=1, `retired`=1; → FETCH.
- EXECR:
  - `alu_in2_ctrl`=0.
  - `alu_ctrl` from `funct3`: 000 gives ADD, or SUB if `funct7b5`=1; 001→SLL, 010→SLT, 011→SLTU, 100→XOR; 101 gives SRL, or SRA if `funct7b5`=1; 110→OR, 111→AND.
  - → ALUWB.
- EXECI:
  - `alu_in2_ctrl`=1, `imm_ctrl`=000.
  - Same `alu_ctrl` decode as EXECR, except `funct3`=000 is always ADD; `funct7b5` is honoured only for `funct3`=101.
  - → ALUWB.
- ALUWB: `reg_write`=1, `regwrite_ctrl`=0, `retired`=1; → FETCH.
- `retire_count` increments by 1 on each rising edge where `retired`=1 and wraps modulo 2^CNT_W.
- `opcode`, `funct3` and `funct7b5` are sampled from the IR; they are stable from DECODE through the end of the instruction.

## Timing
- Reset:
  - state=FETCH, `retire_count`=0, `illegal`=0.
  - All write-enable outputs and `retired` are forced to 0 while `rst`=1, regardless of state.
- The first FETCH is the first rising edge after `rst` deasserts.
- Cycles per instruction, counted from the FETCH edge: R-type 4, I-type 4, SW 4, LW 5.
- `rst` asserted mid-instruction aborts the instruction immediately: no further write enables, and the counter is not incremented.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined:
  - an undecodable opcode or `funct3` in DECODE goes to TRAP.
  - TRAP holds all enables at 0 and sets `illegal`=1; it is left only by reset.
- `CTRL_ILLEGAL_TRAP_EN` undefined:
  - the instruction is treated as a NOP: DECODE → FETCH, `retired` is not pulsed, and TRAP is unreachable.
  - `illegal` is tied to 0.

## Test plan
- IR=0x0020A423 (`sw x2,8(x1)`) → `imm_ctrl`=001 and `alu_in2_ctrl`=1 in cycle 3; `addrsrc_ctrl`=1 and `mem_write`=1 only in cycle 4. With x1=80 and x2=0xCAFEBABE, Memory[22]=0xCAFEBABE and `retire_count`=1.
- IR=0x002081B3 (`add x3,x1,x2`) → `alu_ctrl`=0000 and `alu_in2_ctrl`=0 in EXECR; `reg_write`=1 and `regwrite_ctrl`=0 in cycle 4.
- IR=0x402081B3 (`sub`) → `alu_ctrl`=0001. IR=0x4020D193 (`srai x3,x1,2`) → `alu_ctrl`=0111, `alu_in2_ctrl`=1.
- IR=0x0040A283 (`lw x5,4(x1)`) → `mdr_write`=1 in cycle 4; `reg_write`=1 and `regwrite_ctrl`=1 in cycle 5; next FETCH in cycle 6.
- IR=0xFFFFFFFF:
  - with the macro → `state_o`=9 and `illegal`=1, held for 10 cycles, `pc_write`=0.
  - without the macro → FETCH in cycle 3, `retire_count` unchanged.
- `rst` pulsed during MEMREAD of a LW → outputs 0 asynchronously, `retire_count`=0, FETCH on the first edge after release.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the RV32I multicycle core (R/I ALU, LW, SW) with retired-instruction counter.
// Optional trap on illegal instructions: define CTRL_ILLEGAL_TRAP_EN.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    output logic             pc_write,
    output logic             ir_write,
    output logic             mem_write,
    output logic             reg_write,
    output logic             mdr_write,
    output logic [2:0]       imm_ctrl,
    output logic [3:0]       alu_ctrl,
    output logic             alu_in2_ctrl,
    output logic             addrsrc_ctrl,
    output logic             regwrite_ctrl,
    output logic [3:0]       state_o,
    output logic             retired,
    output logic [CNT_W-1:0] retire_count,
    output logic             illegal
);

    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXECR    = 4'd6;
    localparam logic [3:0] EXECI    = 4'd7;
    localparam logic [3:0] ALUWB    = 4'd8;
    localparam logic [3:0] TRAP     = 4'd9;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;

    logic [3:0] state;
    logic [3:0] next_state;
    logic       is_load;
    logic       is_store;
    logic       bad_next_sel;

    // alt selects SUB for funct3=000 and SRA for funct3=101
    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    assign is_load  = (opcode == OP_LOAD)  && (funct3 == 3'b010);
    assign is_store = (opcode == OP_STORE) && (funct3 == 3'b010);

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign bad_next_sel = 1'b1;
`else
    assign bad_next_sel = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:    next_state = DECODE;
            DECODE: begin
                if (is_load || is_store)  next_state = MEMADR;
                else if (opcode == OP_R)  next_state = EXECR;
                else if (opcode == OP_I)  next_state = EXECI;
                else                      next_state = bad_next_sel ? TRAP : FETCH;
            end
            MEMADR:   next_state = (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
            MEMREAD:  next_state = MEMWB;
            MEMWB:    next_state = FETCH;
            MEMWRITE: next_state = FETCH;
            EXECR:    next_state = ALUWB;
            EXECI:    next_state = ALUWB;
            ALUWB:    next_state = FETCH;
            TRAP:     next_state = bad_next_sel ? TRAP : FETCH;
            default:  next_state = FETCH;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        mdr_write     = 1'b0;
        imm_ctrl      = 3'b000;
        alu_ctrl      = ALU_ADD;
        alu_in2_ctrl  = 1'b0;
        addrsrc_ctrl  = 1'b0;
        regwrite_ctrl = 1'b0;
        retired       = 1'b0;
        case (state)
            FETCH: begin
                pc_write = 1'b1;
                ir_write = 1'b1;
            end
            MEMADR: begin
                alu_in2_ctrl = 1'b1;
                imm_ctrl     = (opcode == OP_STORE) ? 3'b001 : 3'b000;
            end
            MEMREAD: begin
                addrsrc_ctrl = 1'b1;
                mdr_write    = 1'b1;
            end
            MEMWB: begin
                reg_write     = 1'b1;
                regwrite_ctrl = 1'b1;
                retired       = 1'b1;
            end
            MEMWRITE: begin
                addrsrc_ctrl = 1'b1;
                mem_write    = 1'b1;
                retired      = 1'b1;
            end
            EXECR: begin
                alu_ctrl = alu_decode(funct3, funct7b5);
            end
            EXECI: begin
                alu_in2_ctrl = 1'b1;
                alu_ctrl     = alu_decode(funct3, funct7b5 && (funct3 == 3'b101));
            end
            ALUWB: begin
                reg_write = 1'b1;
                retired   = 1'b1;
            end
            default: ;
        endcase
        // Reset must silence the datapath immediately, not at the next edge
        if (rst) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            mdr_write = 1'b0;
            retired   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_count <= '0;
        end else if (retired) begin
            retire_count <= retire_count + 1'b1;
        end
    end

    assign state_o = state;
    // TRAP is exited only through reset, so the state itself is the sticky flag
    assign illegal = bad_next_sel && (state == TRAP);

endmodule
